// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared constants and control-state encoding for sync_ram_dp
package sync_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_t;

endpackage

// File: rtl/sync_ram_rdpipe.sv
// rtl/sync_ram_rdpipe.sv - RD_LATENCY-deep read-data/valid pipeline for one RAM port
module sync_ram_rdpipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [RD_LATENCY-1:0] vld;
    logic [DATA_WIDTH-1:0] dat [RD_LATENCY];

    // Data stages only load behind a valid, so the last stage holds its value between reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                dat[k] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) begin
                    dat[k] <= dat[k-1];
                end
            end
        end
    end

    assign rvalid = vld[RD_LATENCY-1];
    assign rdata  = dat[RD_LATENCY-1];

endmodule

// File: rtl/sync_ram_dp.sv
// rtl/sync_ram_dp.sv - true dual-port byte-writable RAM with post-reset clear and pipelined reads
module sync_ram_dp
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = RDW_READ_FIRST,
    parameter int INIT_ZERO  = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    ready,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic [DATA_WIDTH/8-1:0] b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid
);

    localparam int                  NUM_BYTES = DATA_WIDTH / 8;
    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

    reg [DATA_WIDTH-1:0] ram [0:DEPTH-1];

    ram_state_t            state;
    ram_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  clr_we;

    logic                  a_acc, b_acc;
    logic                  a_ok, b_ok;
    logic                  a_hit, b_hit;
    logic [IDX_W-1:0]      a_idx, b_idx, clr_idx;
    logic [DATA_WIDTH-1:0] a_old, b_old;
    logic [DATA_WIDTH-1:0] a_rd_word, b_rd_word;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (INIT_ZERO != 0) begin
                    clr_we = 1'b1;
                    if (clr_cnt == LAST_WORD) begin
                        state_nxt = ST_RUN;
                    end
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign ready = (state == ST_RUN);

    // Accesses only count once the clear has finished; out-of-range ones still return a valid.
    assign a_acc   = a_en & ready;
    assign b_acc   = b_en & ready;
    assign a_ok    = {1'b0, a_addr} < DEPTH_EXT;
    assign b_ok    = {1'b0, b_addr} < DEPTH_EXT;
    assign a_hit   = a_acc & a_ok;
    assign b_hit   = b_acc & b_ok;
    assign a_idx   = a_addr[IDX_W-1:0];
    assign b_idx   = b_addr[IDX_W-1:0];
    assign clr_idx = clr_cnt[IDX_W-1:0];

    // B is applied first so that A's bytes override on a same-byte collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[clr_idx] <= '0;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (b_hit && b_we[i]) begin
                    ram[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
                end
                if (a_hit && a_we[i]) begin
                    ram[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Cross-port writes are never forwarded; only a port's own write can show in write-first mode.
    always_comb begin
        a_old     = a_ok ? ram[a_idx] : '0;
        b_old     = b_ok ? ram[b_idx] : '0;
        a_rd_word = a_old;
        b_rd_word = b_old;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (a_ok && a_we[i]) begin
                    a_rd_word[i*8 +: 8] = a_wdata[i*8 +: 8];
                end
                if (b_ok && b_we[i]) begin
                    b_rd_word[i*8 +: 8] = b_wdata[i*8 +: 8];
                end
            end
        end
    end

    sync_ram_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe_a (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (a_acc),
        .in_data  (a_rd_word),
        .rvalid   (a_rvalid),
        .rdata    (a_rdata)
    );

    sync_ram_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe_b (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (b_acc),
        .in_data  (b_rd_word),
        .rvalid   (b_rvalid),
        .rdata    (b_rdata)
    );

endmodule

// File: tb/tb_sync_ram_dp.sv
// tb/tb_sync_ram_dp.sv - scoreboard bench for sync_ram_dp in read-first/lat1 and write-first/lat2 builds
module tb_sync_ram_dp;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          a_en, b_en;
    logic [3:0]    a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;

    logic          rdy0, rdy1;
    logic          arv0, brv0, arv1, brv1;
    logic [DW-1:0] ard0, brd0, ard1, brd1;

    sync_ram_dp #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (DEPTH),
        .RD_LATENCY (1), .RDW_MODE (0), .INIT_ZERO (1)
    ) dut0 (
        .clk (clk), .resetn (resetn), .ready (rdy0),
        .a_en (a_en), .a_we (a_we), .a_addr (a_addr), .a_wdata (a_wdata),
        .a_rdata (ard0), .a_rvalid (arv0),
        .b_en (b_en), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata),
        .b_rdata (brd0), .b_rvalid (brv0)
    );

    sync_ram_dp #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (DEPTH),
        .RD_LATENCY (2), .RDW_MODE (1), .INIT_ZERO (1)
    ) dut1 (
        .clk (clk), .resetn (resetn), .ready (rdy1),
        .a_en (a_en), .a_we (a_we), .a_addr (a_addr), .a_wdata (a_wdata),
        .a_rdata (ard1), .a_rvalid (arv1),
        .b_en (b_en), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata),
        .b_rdata (brd1), .b_rvalid (brv1)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sbq [4][$];
    logic [DW-1:0] last_rd [4];
    logic [DW-1:0] mem [DEPTH];
    int            cyc = 0;
    int            run_edges = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) run_edges <= 0;
        else         run_edges <= run_edges + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string pname(input int k);
        return $sformatf("d%0d_%s", k / 2, (k % 2 == 0) ? "a" : "b");
    endfunction

    task automatic mon_port(input int k, input logic rv, input logic [DW-1:0] rd);
        exp_t e;
        if (rv) begin
            if (sbq[k].size() == 0) begin
                check({pname(k), "_spurious_rvalid"}, 1, 0);
            end else begin
                e = sbq[k].pop_front();
                check({pname(k), "_rdata"}, rd, e.data);
                check({pname(k), "_latency"}, cyc, e.due);
                last_rd[k] = e.data;
            end
        end else begin
            check({pname(k), "_rdata_hold"}, rd, last_rd[k]);
            if (sbq[k].size() != 0 && sbq[k][0].due <= cyc) begin
                e = sbq[k].pop_front();
                check({pname(k), "_missing_rvalid"}, 0, 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            mon_port(0, arv0, ard0);
            mon_port(1, brv0, brd0);
            mon_port(2, arv1, ard1);
            mon_port(3, brv1, brd1);
        end
    end

    function automatic logic [DW-1:0] merge(input logic ok, input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd, input logic [3:0] we);
        logic [DW-1:0] r;
        if (!ok) return '0;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    task automatic push(input int k, input logic [DW-1:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.due  = cyc + lat;
        sbq[k].push_back(e);
    endtask

    // Drive one cycle of stimulus; predictions are made from the model before it absorbs the writes.
    task automatic access(input logic ae, input logic [3:0] awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                          input logic be, input logic [3:0] bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
        logic          aok, bok;
        logic [DW-1:0] ao, bo;
        a_en = ae; a_we = awe; a_addr = aad; a_wdata = awd;
        b_en = be; b_we = bwe; b_addr = bad; b_wdata = bwd;
        if (run_edges >= DEPTH) begin
            aok = (aad < DEPTH);
            bok = (bad < DEPTH);
            ao  = aok ? mem[aad[3:0]] : '0;
            bo  = bok ? mem[bad[3:0]] : '0;
            if (ae) begin
                push(0, ao, 1);
                push(2, merge(aok, ao, awd, awe), 2);
            end
            if (be) begin
                push(1, bo, 1);
                push(3, merge(bok, bo, bwd, bwe), 2);
            end
            if (be && bok) mem[bad[3:0]] = merge(1'b1, mem[bad[3:0]], bwd, bwe);
            if (ae && aok) mem[aad[3:0]] = merge(1'b1, mem[aad[3:0]], awd, awe);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready0"}, rdy0, 0);
        check({tag, "_ready1"}, rdy1, 0);
        check({tag, "_rvalid"}, {arv0, brv0, arv1, brv1}, 0);
        check({tag, "_d0_rdata"}, ard0 | brd0, 0);
        check({tag, "_d1_rdata"}, ard1 | brd1, 0);
    endtask

    initial begin
        resetn = 1'b0;
        a_en = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_en = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        for (int k = 0; k < 4; k++) last_rd[k] = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");

        // Interrupt the clear after 8 edges; it must restart from word 0.
        resetn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_outputs_zero("midclear_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Enables held through the whole clear must be ignored, including the final clear edge.
        a_en = 1; a_we = 4'hF; a_addr = 8'd2; a_wdata = 32'h12345678;
        b_en = 1; b_we = 4'hF; b_addr = 8'd9; b_wdata = 32'h9ABCDEF0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ready0_edge%0d", i), rdy0, (i == DEPTH));
            check($sformatf("ready1_edge%0d", i), rdy1, (i == DEPTH));
        end
        a_en = 0; b_en = 0;

        for (int i = 0; i < DEPTH; i++)
            access(1, 4'h0, AW'(i), '0, 1, 4'h0, AW'(DEPTH - 1 - i), '0);
        idle(3);

        access(1, 4'hF,    8'd5, 32'h11223344, 0, 4'h0, '0, '0);
        access(1, 4'b0101, 8'd5, 32'hDEADBEEF, 0, 4'h0, '0, '0);
        access(1, 4'h0,    8'd5, '0,           1, 4'h0, 8'd5, '0);
        idle(3);

        access(1, 4'hF, 8'd3, 32'hCAFEF00D, 0, 4'h0, '0, '0);
        access(0, 4'h0, '0, '0,             1, 4'h0, 8'd3, '0);
        idle(3);

        access(1, 4'hF, 8'd7, 32'hAAAAAAAA, 1, 4'hF, 8'd7, 32'h55555555);
        access(1, 4'h0, 8'd7, '0,           0, 4'h0, '0, '0);
        access(1, 4'hF, 8'd7, 32'h01020304, 1, 4'h0, 8'd7, '0);
        access(1, 4'h0, 8'd7, '0,           1, 4'h0, 8'd7, '0);
        idle(3);

        // Out-of-range addresses must neither write nor alias onto low words.
        access(1, 4'hF, 8'd20, 32'hFFFFFFFF, 1, 4'hF, 8'd16, 32'hEEEEEEEE);
        access(1, 4'h0, 8'd4,  '0,           1, 4'h0, 8'd0,  '0);
        access(1, 4'h0, 8'd20, '0,           1, 4'h0, 8'd255, '0);
        idle(3);

        for (int n = 0; n < 80; n++) begin
            access(1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom_range(0, 17)), $urandom,
                   1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom_range(0, 17)), $urandom);
        end
        idle(4);
        for (int k = 0; k < 4; k++) check({pname(k), "_queue_drained"}, sbq[k].size(), 0);

        access(1, 4'hF, 8'd7, 32'h5A5A0FF0, 1, 4'h0, 8'd7, '0);
        access(1, 4'h0, 8'd7, '0,           1, 4'h0, 8'd7, '0);
        idle(3);
        #2;
        resetn = 1'b0;
        #1;
        check_outputs_zero("async_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
